// File: rtl/lime_io_pkg.sv
// Shared constants for the lime I/O port: register-window offsets and STATUS/CONTROL bit indices.
package lime_io_pkg;

    // Word offsets inside the 4-word window
    localparam logic [1:0] OFS_DATA_IN  = 2'd0;
    localparam logic [1:0] OFS_DATA_OUT = 2'd1;
    localparam logic [1:0] OFS_STATUS   = 2'd2;
    localparam logic [1:0] OFS_CONTROL  = 2'd3;

    // STATUS register bit positions
    localparam int unsigned ST_IN_NOT_EMPTY = 0;
    localparam int unsigned ST_OUT_NOT_FULL = 1;
    localparam int unsigned ST_IN_UNF       = 2;
    localparam int unsigned ST_OUT_OVF      = 3;

    // CONTROL register bit positions (write 1 to clear)
    localparam int unsigned CTL_CLR_IN_UNF  = 0;
    localparam int unsigned CTL_CLR_OUT_OVF = 1;

endpackage

// File: rtl/lime_fifo.sv
// Count-based synchronous FIFO. Full/empty come from the registered count only, so a pop in
// the same cycle never makes room for a push (and a push never feeds a same-cycle pop).
module lime_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_head,
    output logic             o_full,
    output logic             o_empty
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wptr;
    logic [PW-1:0]    r_rptr;
    logic [CW-1:0]    r_count;
    logic             w_push_ok;
    logic             w_pop_ok;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rptr];
    assign w_push_ok = i_push & ~o_full;
    assign w_pop_ok  = i_pop & ~o_empty;

    // Storage array; contents need no reset since pointers/count define validity
    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wptr] <= i_data;
        end
    end

    // Pointer and occupancy update; pointers wrap modulo DEPTH (power of 2)
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push_ok) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_pop_ok) begin
                r_rptr <= r_rptr + PW'(1);
            end
            unique case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/lime_io_port.sv
// Memory-mapped I/O responder: decodes a 4-word window on the data-memory bus, buffers
// host->CPU and CPU->host words in two FIFOs, and keeps sticky underflow/overflow flags.
module lime_io_port
    import lime_io_pkg::*;
#(
    parameter logic [15:0]  IO_BASE = 16'hFF00,
    parameter int unsigned  DEPTH   = 4,
    parameter int unsigned  WIDTH   = 16
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [15:0]      i_cpu_addr,
    input  logic             i_cpu_read,
    input  logic             i_cpu_write,
    input  logic [WIDTH-1:0] i_cpu_wdata,
    output logic [WIDTH-1:0] o_cpu_rdata,
    output logic             o_cpu_hit,
    input  logic [WIDTH-1:0] i_host_in_data,
    input  logic             i_host_in_valid,
    output logic             o_host_in_ready,
    output logic [WIDTH-1:0] o_host_out_data,
    output logic             o_host_out_valid,
    input  logic             i_host_out_ready
);
    logic [1:0]       w_offset;
    logic             w_hit;
    logic             w_wr;
    logic             w_rd_only;
    logic             w_in_pop;
    logic             w_out_push;
    logic             w_ctl_wr;
    logic             w_unf_set;
    logic             w_ovf_set;
    logic             w_unf_clr;
    logic             w_ovf_clr;
    logic [WIDTH-1:0] w_in_head;
    logic             w_in_full;
    logic             w_in_empty;
    logic             w_out_full;
    logic             w_out_empty;
    logic [WIDTH-1:0] w_status;
    logic [WIDTH-1:0] w_rdata_d;
    logic             r_in_unf;
    logic             r_out_ovf;
    logic [WIDTH-1:0] r_rdata;
    logic             r_hit;

    // Address decode; IO_BASE low bits are zero so the offset is just the low address bits.
    // When read and write strobe together the write acts and the read is side-effect free.
    assign w_offset   = i_cpu_addr[1:0];
    assign w_hit      = (i_cpu_addr[15:2] == IO_BASE[15:2]);
    assign w_wr       = w_hit & i_cpu_write;
    assign w_rd_only  = w_hit & i_cpu_read & ~i_cpu_write;
    assign w_in_pop   = w_rd_only & (w_offset == OFS_DATA_IN);
    assign w_out_push = w_wr & (w_offset == OFS_DATA_OUT);
    assign w_ctl_wr   = w_wr & (w_offset == OFS_CONTROL);
    assign w_unf_set  = w_in_pop & w_in_empty;
    assign w_ovf_set  = w_out_push & w_out_full;
    assign w_unf_clr  = w_ctl_wr & i_cpu_wdata[CTL_CLR_IN_UNF];
    assign w_ovf_clr  = w_ctl_wr & i_cpu_wdata[CTL_CLR_OUT_OVF];

    lime_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_in_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (i_host_in_valid),
        .i_data  (i_host_in_data),
        .i_pop   (w_in_pop),
        .o_head  (w_in_head),
        .o_full  (w_in_full),
        .o_empty (w_in_empty)
    );

    lime_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_out_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .i_push  (w_out_push),
        .i_data  (i_cpu_wdata),
        .i_pop   (i_host_out_ready),
        .o_head  (o_host_out_data),
        .o_full  (w_out_full),
        .o_empty (w_out_empty)
    );

    assign o_host_in_ready  = ~w_in_full;
    assign o_host_out_valid = ~w_out_empty;

    // Assemble STATUS word and select the next read-data value
    always_comb begin
        w_status                  = '0;
        w_status[ST_IN_NOT_EMPTY] = ~w_in_empty;
        w_status[ST_OUT_NOT_FULL] = ~w_out_full;
        w_status[ST_IN_UNF]       = r_in_unf;
        w_status[ST_OUT_OVF]      = r_out_ovf;
        w_rdata_d                 = '0;
        if (w_rd_only) begin
            unique case (w_offset)
                OFS_DATA_IN: begin
                    if (!w_in_empty) begin
                        w_rdata_d = w_in_head;
                    end
                end
                OFS_STATUS: w_rdata_d = w_status;
                default:    w_rdata_d = '0;
            endcase
        end
    end

    // Registered bus response and sticky flags; a set on the same edge as a clear wins
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rdata   <= '0;
            r_hit     <= 1'b0;
            r_in_unf  <= 1'b0;
            r_out_ovf <= 1'b0;
        end else begin
            r_rdata   <= w_rdata_d;
            r_hit     <= w_hit & (i_cpu_read | i_cpu_write);
            r_in_unf  <= w_unf_set | (r_in_unf & ~w_unf_clr);
            r_out_ovf <= w_ovf_set | (r_out_ovf & ~w_ovf_clr);
        end
    end

    assign o_cpu_rdata = r_rdata;
    assign o_cpu_hit   = r_hit;

endmodule

// File: tb/tb_lime_io_port.sv
// Directed bench for lime_io_port: a vector table for the main register behaviour plus
// hand-written sequences for simultaneous push/pop, full input FIFO and reset mid-transfer.
module tb_lime_io_port;

    logic        clk;
    logic        reset;
    logic [15:0] cpu_addr;
    logic        cpu_read;
    logic        cpu_write;
    logic [15:0] cpu_wdata;
    logic [15:0] cpu_rdata;
    logic        cpu_hit;
    logic [15:0] host_in_data;
    logic        host_in_valid;
    logic        host_in_ready;
    logic [15:0] host_out_data;
    logic        host_out_valid;
    logic        host_out_ready;

    int n_checks;
    int n_fail;

    lime_io_port #(
        .IO_BASE (16'hFF00),
        .DEPTH   (4),
        .WIDTH   (16)
    ) dut (
        .i_clk            (clk),
        .i_reset          (reset),
        .i_cpu_addr       (cpu_addr),
        .i_cpu_read       (cpu_read),
        .i_cpu_write      (cpu_write),
        .i_cpu_wdata      (cpu_wdata),
        .o_cpu_rdata      (cpu_rdata),
        .o_cpu_hit        (cpu_hit),
        .i_host_in_data   (host_in_data),
        .i_host_in_valid  (host_in_valid),
        .o_host_in_ready  (host_in_ready),
        .o_host_out_data  (host_out_data),
        .o_host_out_valid (host_out_valid),
        .i_host_out_ready (host_out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rd;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        hiv;
        logic [15:0] hid;
        logic        hor;
        logic [15:0] exp_rdata;
        logic        exp_hit;
        logic        exp_ir;
        logic        exp_ov;
        logic [15:0] exp_od;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rd, logic wr, logic [15:0] addr, logic [15:0] wdata,
                                logic hiv, logic [15:0] hid, logic hor,
                                logic [15:0] exp_rdata, logic exp_hit, logic exp_ir,
                                logic exp_ov, logic [15:0] exp_od);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
        v.hiv = hiv; v.hid = hid; v.hor = hor;
        v.exp_rdata = exp_rdata; v.exp_hit = exp_hit; v.exp_ir = exp_ir;
        v.exp_ov = exp_ov; v.exp_od = exp_od;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the rising edge
    task automatic cyc(input logic rd, input logic wr, input logic [15:0] addr,
                       input logic [15:0] wdata, input logic hiv, input logic [15:0] hid,
                       input logic hor);
        cpu_read       = rd;
        cpu_write      = wr;
        cpu_addr       = addr;
        cpu_wdata      = wdata;
        host_in_valid  = hiv;
        host_in_data   = hid;
        host_out_ready = hor;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset    = 1'b1;
        idle();
        idle();
        check("reset_rdata", cpu_rdata, 16'h0000);
        check("reset_hit", {15'd0, cpu_hit}, 16'd0);
        check("reset_in_ready", {15'd0, host_in_ready}, 16'd1);
        check("reset_out_valid", {15'd0, host_out_valid}, 16'd0);
        reset = 1'b0;

        //              rd    wr    addr      wdata     hiv   hid       hor   rdata     hit   ir    ov    od
        vecs.push_back(mk(1'b1, 1'b0, 16'hFF02, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0002, 1'b1, 1'b1, 1'b0, 16'h0));
        vecs.push_back(mk(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'hA5A5, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0));
        vecs.push_back(mk(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h1234, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0));
        vecs.push_back(mk(1'b1, 1'b0, 16'hFF02, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0003, 1'b1, 1'b1, 1'b0, 16'h0));
        vecs.push_back(mk(1'b1, 1'b0, 16'hFF00, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'hA5A5, 1'b1, 1'b1, 1'b0, 16'h0));
        vecs.push_back(mk(1'b1, 1'b0, 16'hFF00, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h1234, 1'b1, 1'b1, 1'b0, 16'h0));
        vecs.push_back(mk(1'b1, 1'b0, 16'hFF02, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0002, 1'b1, 1'b1, 1'b0, 16'h0));
        // Fill output FIFO with host stalled; fifth word overflows
        vecs.push_back(mk(1'b0, 1'b1, 16'hFF01, 16'h1111, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h1111));
        vecs.push_back(mk(1'b0, 1'b1, 16'hFF01, 16'h2222, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h1111));
        vecs.push_back(mk(1'b0, 1'b1, 16'hFF01, 16'h3333, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h1111));
        vecs.push_back(mk(1'b0, 1'b1, 16'hFF01, 16'h4444, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h1111));
        vecs.push_back(mk(1'b0, 1'b1, 16'hFF01, 16'h5555, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h1111));
        vecs.push_back(mk(1'b1, 1'b0, 16'hFF02, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0008, 1'b1, 1'b1, 1'b1, 16'h1111));
        vecs.push_back(mk(1'b0, 1'b1, 16'hFF03, 16'h0002, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h1111));
        vecs.push_back(mk(1'b1, 1'b0, 16'hFF02, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h1111));
        vecs.push_back(mk(1'b1, 1'b0, 16'hFF01, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h1111));
        vecs.push_back(mk(1'b1, 1'b0, 16'hFF03, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h1111));
        // Underflow, then clear via CONTROL bit0
        vecs.push_back(mk(1'b1, 1'b0, 16'hFF00, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h1111));
        vecs.push_back(mk(1'b1, 1'b0, 16'hFF02, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0004, 1'b1, 1'b1, 1'b1, 16'h1111));
        vecs.push_back(mk(1'b0, 1'b1, 16'hFF03, 16'h0001, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h1111));
        vecs.push_back(mk(1'b1, 1'b0, 16'hFF02, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h1111));
        // Host pops one; read+write together pushes 6666 only
        vecs.push_back(mk(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h2222));
        vecs.push_back(mk(1'b1, 1'b1, 16'hFF01, 16'h6666, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h2222));
        // CPU push while full + host pop same edge: push dropped, pop happens, overflow set
        vecs.push_back(mk(1'b0, 1'b1, 16'hFF01, 16'h7777, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b1, 1'b1, 16'h3333));
        vecs.push_back(mk(1'b1, 1'b0, 16'hFF02, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h000A, 1'b1, 1'b1, 1'b1, 16'h3333));
        vecs.push_back(mk(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h4444));
        vecs.push_back(mk(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 16'h6666));
        vecs.push_back(mk(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000));
        vecs.push_back(mk(1'b0, 1'b1, 16'hFF03, 16'h0003, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 16'h0000));
        // Just outside the window on either side
        vecs.push_back(mk(1'b1, 1'b0, 16'hFF04, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000));
        vecs.push_back(mk(1'b1, 1'b0, 16'hFEFF, 16'h0000, 1'b0, 16'h0000, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 16'h0000));

        foreach (vecs[i]) begin
            cyc(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].hiv, vecs[i].hid,
                vecs[i].hor);
            check($sformatf("v%0d_rdata", i), cpu_rdata, vecs[i].exp_rdata);
            check($sformatf("v%0d_hit", i), {15'd0, cpu_hit}, {15'd0, vecs[i].exp_hit});
            check($sformatf("v%0d_in_ready", i), {15'd0, host_in_ready}, {15'd0, vecs[i].exp_ir});
            check($sformatf("v%0d_out_valid", i), {15'd0, host_out_valid},
                  {15'd0, vecs[i].exp_ov});
            if (vecs[i].exp_ov) begin
                check($sformatf("v%0d_out_data", i), host_out_data, vecs[i].exp_od);
            end
        end

        // Host push and CPU pop on the same edge with two words buffered
        cyc(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0001, 1'b0);
        cyc(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'h0002, 1'b0);
        cyc(1'b1, 1'b0, 16'hFF00, 16'h0000, 1'b1, 16'h0003, 1'b0);
        check("simul_pop0", cpu_rdata, 16'h0001);
        cyc(1'b1, 1'b0, 16'hFF00, 16'h0000, 1'b0, 16'h0000, 1'b0);
        check("simul_pop1", cpu_rdata, 16'h0002);
        cyc(1'b1, 1'b0, 16'hFF00, 16'h0000, 1'b0, 16'h0000, 1'b0);
        check("simul_pop2", cpu_rdata, 16'h0003);
        cyc(1'b1, 1'b0, 16'hFF02, 16'h0000, 1'b0, 16'h0000, 1'b0);
        check("simul_status", cpu_rdata, 16'h0002);

        // Fill input FIFO; extra host word is refused while full
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'hA000 + 16'(k), 1'b0);
        end
        check("in_full_ready", {15'd0, host_in_ready}, 16'd0);
        cyc(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b1, 16'hDEAD, 1'b0);
        check("in_full_ready_hold", {15'd0, host_in_ready}, 16'd0);

        // Fill output FIFO
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 1'b1, 16'hFF01, 16'hB000 + 16'(k), 1'b0, 16'h0000, 1'b0);
        end
        check("out_full_data", host_out_data, 16'hB000);

        // Strobes outside the window change nothing
        cyc(1'b1, 1'b0, 16'h1000, 16'h0000, 1'b0, 16'h0000, 1'b0);
        check("miss_rd_hit", {15'd0, cpu_hit}, 16'd0);
        check("miss_rd_rdata", cpu_rdata, 16'h0000);
        cyc(1'b0, 1'b1, 16'h1001, 16'hCCCC, 1'b0, 16'h0000, 1'b0);
        check("miss_wr_hit", {15'd0, cpu_hit}, 16'd0);
        cyc(1'b1, 1'b0, 16'hFF02, 16'h0000, 1'b0, 16'h0000, 1'b0);
        check("full_status", cpu_rdata, 16'h0001);
        cyc(1'b1, 1'b0, 16'hFF00, 16'h0000, 1'b0, 16'h0000, 1'b0);
        check("full_in_head", cpu_rdata, 16'hA000);

        // Reset mid-transfer with both FIFOs holding words
        reset = 1'b1;
        cyc(1'b1, 1'b0, 16'hFF00, 16'h0000, 1'b1, 16'hBEEF, 1'b0);
        check("rst_mid_rdata", cpu_rdata, 16'h0000);
        check("rst_mid_hit", {15'd0, cpu_hit}, 16'd0);
        check("rst_mid_in_ready", {15'd0, host_in_ready}, 16'd1);
        check("rst_mid_out_valid", {15'd0, host_out_valid}, 16'd0);
        reset = 1'b0;
        cyc(1'b1, 1'b0, 16'hFF02, 16'h0000, 1'b0, 16'h0000, 1'b0);
        check("post_rst_status", cpu_rdata, 16'h0002);
        cyc(1'b1, 1'b0, 16'hFF00, 16'h0000, 1'b0, 16'h0000, 1'b0);
        check("post_rst_pop", cpu_rdata, 16'h0000);
        cyc(1'b1, 1'b0, 16'hFF02, 16'h0000, 1'b0, 16'h0000, 1'b0);
        check("post_rst_unf", cpu_rdata, 16'h0006);

        idle();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
